// File: rtl/vector_data_mem.sv
// vector_data_mem: 256-bit word memory behind the data aligner's ip_ram port.
// Zero-fills every word after reset, then serves one read and/or write per
// cycle with per-byte write enables and a registered, 1-cycle read path.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | zero-fill sweep, one word per cycle; requests are ignored
// ST_RUN  | serving requests; left only through reset
module vector_data_mem #(
    parameter int V     = 256,
    parameter int DEPTH = 1024,
    parameter int AW    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rden,
    input  logic              wren,
    input  logic [AW-1:0]     ip_address,
    input  logic [V/8-1:0]    byteena,
    input  logic [V-1:0]      writeData,
    output logic [V-1:0]      readData,
    output logic              init_done,
    output logic              addr_err
);

    localparam int          NB      = V / 8;
    localparam int          DAW     = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [DAW-1:0]   r_fill_cnt;
    logic [V-1:0]     r_mem [DEPTH];
    logic [V-1:0]     r_read_data;
    logic             r_init_done;
    logic             r_addr_err;

    logic             w_in_range;
    logic             w_mem_we;
    logic [DAW-1:0]   w_mem_addr;
    logic [V-1:0]     w_mem_wdata;
    logic [NB-1:0]    w_mem_be;

    // Indices at or above DEPTH are flagged, never aliased onto low words.
    assign w_in_range = {1'b0, ip_address} < DEPTH_X;

    // Single array write port shared by the fill sweep and normal writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_be    = '0;
        if (r_state == ST_INIT) begin
            w_mem_we    = rst;
            w_mem_addr  = r_fill_cnt;
            w_mem_wdata = '0;
            w_mem_be    = '1;
        end else begin
            w_mem_we    = wren && w_in_range;
            w_mem_addr  = ip_address[DAW-1:0];
            w_mem_wdata = writeData;
            w_mem_be    = byteena;
        end
    end

    // Byte-lane array update; contents are cleared by the sweep, not by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_mem_we && w_mem_be[i]) begin
                r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
            end
        end
    end

    // Sequencing FSM with registered read data, init flag and error pulse.
    // The read samples the array before the same-edge write lands, giving
    // read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_fill_cnt  <= '0;
            r_read_data <= '0;
            r_init_done <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_addr_err <= 1'b0;
                    if (r_fill_cnt == DAW'(DEPTH - 1)) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_addr_err <= (rden || wren) && !w_in_range;
                    if (rden) begin
                        r_read_data <= w_in_range ? r_mem[ip_address[DAW-1:0]] : '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign readData  = r_read_data;
    assign init_done = r_init_done;
    assign addr_err  = r_addr_err;

endmodule
